// File: rtl/universal_reg_nbit.sv
// WIDTH-bit working register with load, shift, rotate and inc/dec operations,
// serial chaining pins, and registered carry / changed flags.
module universal_reg_nbit #(
  parameter int unsigned       WIDTH     = 8,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             enable_i,
  input  logic [2:0]       mode_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             ser_in_l_i,
  input  logic             ser_in_r_i,
  output logic [WIDTH-1:0] q_o,
  output logic             ser_out_l_o,
  output logic             ser_out_r_o,
  output logic             carry_o,
  output logic             changed_o,
  output logic             zero_o
);

  localparam logic [2:0] ModeHold = 3'b000;
  localparam logic [2:0] ModeLoad = 3'b001;
  localparam logic [2:0] ModeShl  = 3'b010;
  localparam logic [2:0] ModeShr  = 3'b011;
  localparam logic [2:0] ModeRol  = 3'b100;
  localparam logic [2:0] ModeRor  = 3'b101;
  localparam logic [2:0] ModeInc  = 3'b110;
  localparam logic [2:0] ModeDec  = 3'b111;

  logic [WIDTH-1:0] q_q, q_d;
  logic             carry_q, carry_d;
  logic             changed_q, changed_d;

  always_comb begin
    q_d     = q_q;
    carry_d = carry_q;
    if (enable_i) begin
      unique case (mode_i)
        ModeHold: begin
          q_d     = q_q;
          carry_d = carry_q;
        end
        ModeLoad: begin
          q_d     = d_i;
          carry_d = 1'b0;
        end
        ModeShl: begin
          q_d     = {q_q[WIDTH-2:0], ser_in_r_i};
          carry_d = q_q[WIDTH-1];
        end
        ModeShr: begin
          q_d     = {ser_in_l_i, q_q[WIDTH-1:1]};
          carry_d = q_q[0];
        end
        ModeRol: begin
          q_d     = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          carry_d = q_q[WIDTH-1];
        end
        ModeRor: begin
          q_d     = {q_q[0], q_q[WIDTH-1:1]};
          carry_d = q_q[0];
        end
        ModeInc: begin
          q_d     = q_q + 1'b1;
          carry_d = &q_q;
        end
        ModeDec: begin
          q_d     = q_q - 1'b1;
          carry_d = ~|q_q;
        end
        default: begin
          q_d     = q_q;
          carry_d = carry_q;
        end
      endcase
    end
    // Pulse only when the stored value actually moves, so idempotent ops stay quiet.
    changed_d = enable_i && (q_d != q_q);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      q_q       <= RESET_VAL;
      carry_q   <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      carry_q   <= carry_d;
      changed_q <= changed_d;
    end
  end

  assign q_o         = q_q;
  assign ser_out_l_o = q_q[WIDTH-1];
  assign ser_out_r_o = q_q[0];
  assign carry_o     = carry_q;
  assign changed_o   = changed_q;
  assign zero_o      = (q_q == '0);

endmodule

// File: tb/tb_universal_reg_nbit.sv
// Directed bench for universal_reg_nbit: an 8-bit instance (RESET_VAL=5A) plus
// 4- and 16-bit instances sharing the same control stimulus.
module tb_universal_reg_nbit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [2:0]  mode;
  logic [15:0] d;
  logic        ser_in_l;
  logic        ser_in_r;

  logic [7:0]  q8;
  logic        sol8, sor8, carry8, changed8, zero8;
  logic [3:0]  q4;
  logic        sol4, sor4, carry4, changed4, zero4;
  logic [15:0] q16;
  logic        sol16, sor16, carry16, changed16, zero16;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  universal_reg_nbit #(.WIDTH(8), .RESET_VAL(8'h5A)) u_dut8 (
    .clk_i(clk), .reset_ni(reset_n), .enable_i(enable), .mode_i(mode), .d_i(d[7:0]),
    .ser_in_l_i(ser_in_l), .ser_in_r_i(ser_in_r), .q_o(q8), .ser_out_l_o(sol8),
    .ser_out_r_o(sor8), .carry_o(carry8), .changed_o(changed8), .zero_o(zero8)
  );

  universal_reg_nbit #(.WIDTH(4), .RESET_VAL(4'h0)) u_dut4 (
    .clk_i(clk), .reset_ni(reset_n), .enable_i(enable), .mode_i(mode), .d_i(d[3:0]),
    .ser_in_l_i(ser_in_l), .ser_in_r_i(ser_in_r), .q_o(q4), .ser_out_l_o(sol4),
    .ser_out_r_o(sor4), .carry_o(carry4), .changed_o(changed4), .zero_o(zero4)
  );

  universal_reg_nbit #(.WIDTH(16), .RESET_VAL(16'h0000)) u_dut16 (
    .clk_i(clk), .reset_ni(reset_n), .enable_i(enable), .mode_i(mode), .d_i(d),
    .ser_in_l_i(ser_in_l), .ser_in_r_i(ser_in_r), .q_o(q16), .ser_out_l_o(sol16),
    .ser_out_r_o(sor16), .carry_o(carry16), .changed_o(changed16), .zero_o(zero16)
  );

  // Apply one cycle of stimulus, then settle just past the rising edge.
  task automatic step(input logic rn, input logic en, input logic [2:0] md,
                      input logic [15:0] dv, input logic sl, input logic sr);
    reset_n  = rn;
    enable   = en;
    mode     = md;
    d        = dv;
    ser_in_l = sl;
    ser_in_r = sr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    step(1'b0, 1'b0, 3'b000, 16'h0000, 1'b0, 1'b0);
    checks++; if (q8 !== 8'h5A) $display("FAIL reset_q got %h want 5a", q8); else passed++;
    checks++; if (carry8 !== 1'b0) $display("FAIL reset_carry got %b want 0", carry8); else passed++;
    checks++; if (changed8 !== 1'b0) $display("FAIL reset_changed got %b want 0", changed8);
    else passed++;
    checks++; if (zero8 !== 1'b0) $display("FAIL reset_zero got %b want 0", zero8); else passed++;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 3'b001, 16'h00FF, 1'b0, 1'b0);
      checks++; if (q8 !== 8'h5A) $display("FAIL hold_q[%0d] got %h want 5a", i, q8); else passed++;
      checks++; if (changed8 !== 1'b0) $display("FAIL hold_changed[%0d] got %b want 0", i, changed8);
      else passed++;
    end
  endtask

  task automatic test_load_shift;
    step(1'b1, 1'b1, 3'b001, 16'h00AA, 1'b0, 1'b0);
    checks++; if (q8 !== 8'hAA) $display("FAIL load_q got %h want aa", q8); else passed++;
    checks++; if (changed8 !== 1'b1) $display("FAIL load_changed got %b want 1", changed8); else passed++;
    step(1'b1, 1'b1, 3'b010, 16'h0000, 1'b0, 1'b1);
    checks++; if (q8 !== 8'h55) $display("FAIL shl_q got %h want 55", q8); else passed++;
    checks++; if (carry8 !== 1'b1) $display("FAIL shl_carry got %b want 1", carry8); else passed++;
    checks++; if ({sol8, sor8} !== 2'b01) $display("FAIL shl_serout got %b want 01", {sol8, sor8});
    else passed++;
    step(1'b1, 1'b1, 3'b011, 16'h0000, 1'b0, 1'b0);
    checks++; if (q8 !== 8'h2A) $display("FAIL shr_q got %h want 2a", q8); else passed++;
    checks++; if (carry8 !== 1'b1) $display("FAIL shr_carry got %b want 1", carry8); else passed++;
    checks++; if ({sol8, sor8} !== 2'b00) $display("FAIL shr_serout got %b want 00", {sol8, sor8});
    else passed++;
    step(1'b1, 1'b1, 3'b011, 16'h0000, 1'b1, 1'b0);
    checks++; if (q8 !== 8'h95) $display("FAIL shr1_q got %h want 95", q8); else passed++;
    checks++; if (carry8 !== 1'b0) $display("FAIL shr1_carry got %b want 0", carry8); else passed++;
  endtask

  task automatic test_rotate;
    step(1'b1, 1'b1, 3'b001, 16'h0081, 1'b0, 1'b0);
    step(1'b1, 1'b1, 3'b100, 16'h0000, 1'b0, 1'b0);
    checks++; if (q8 !== 8'h03) $display("FAIL rol_q got %h want 03", q8); else passed++;
    checks++; if (carry8 !== 1'b1) $display("FAIL rol_carry got %b want 1", carry8); else passed++;
    step(1'b1, 1'b1, 3'b101, 16'h0000, 1'b0, 1'b0);
    checks++; if (q8 !== 8'h81) $display("FAIL ror_q got %h want 81", q8); else passed++;
    checks++; if (carry8 !== 1'b1) $display("FAIL ror_carry got %b want 1", carry8); else passed++;
    step(1'b1, 1'b1, 3'b001, 16'h0000, 1'b0, 1'b0);
    checks++; if (zero8 !== 1'b1) $display("FAIL load0_zero got %b want 1", zero8); else passed++;
    step(1'b1, 1'b1, 3'b100, 16'h0000, 1'b0, 1'b0);
    checks++; if (q8 !== 8'h00) $display("FAIL rol0_q got %h want 00", q8); else passed++;
    checks++; if (changed8 !== 1'b0) $display("FAIL rol0_changed got %b want 0", changed8);
    else passed++;
    step(1'b1, 1'b1, 3'b001, 16'h0000, 1'b0, 1'b0);
    checks++; if (changed8 !== 1'b0) $display("FAIL load_same_changed got %b want 0", changed8);
    else passed++;
  endtask

  task automatic test_counter_wrap;
    step(1'b1, 1'b1, 3'b001, 16'h00FE, 1'b0, 1'b0);
    step(1'b1, 1'b1, 3'b110, 16'h0000, 1'b0, 1'b0);
    checks++; if (q8 !== 8'hFF) $display("FAIL inc1_q got %h want ff", q8); else passed++;
    checks++; if (carry8 !== 1'b0) $display("FAIL inc1_carry got %b want 0", carry8); else passed++;
    step(1'b1, 1'b1, 3'b110, 16'h0000, 1'b0, 1'b0);
    checks++; if (q8 !== 8'h00) $display("FAIL inc2_q got %h want 00", q8); else passed++;
    checks++; if (carry8 !== 1'b1) $display("FAIL inc2_carry got %b want 1", carry8); else passed++;
    checks++; if (zero8 !== 1'b1) $display("FAIL inc2_zero got %b want 1", zero8); else passed++;
    step(1'b1, 1'b1, 3'b111, 16'h0000, 1'b0, 1'b0);
    checks++; if (q8 !== 8'hFF) $display("FAIL dec_q got %h want ff", q8); else passed++;
    checks++; if (carry8 !== 1'b1) $display("FAIL dec_carry got %b want 1", carry8); else passed++;
    checks++; if (zero8 !== 1'b0) $display("FAIL dec_zero got %b want 0", zero8); else passed++;
    step(1'b1, 1'b1, 3'b000, 16'h0000, 1'b0, 1'b0);
    checks++; if (q8 !== 8'hFF) $display("FAIL hold_en_q got %h want ff", q8); else passed++;
    checks++; if (carry8 !== 1'b1) $display("FAIL hold_en_carry got %b want 1", carry8); else passed++;
    checks++; if (changed8 !== 1'b0) $display("FAIL hold_en_changed got %b want 0", changed8);
    else passed++;
    step(1'b1, 1'b0, 3'b110, 16'h0000, 1'b0, 1'b0);
    checks++; if ({q8, carry8} !== {8'hFF, 1'b1})
      $display("FAIL disabled_inc got %h/%b want ff/1", q8, carry8);
    else passed++;
  endtask

  task automatic test_reset_mid_op;
    step(1'b1, 1'b1, 3'b001, 16'h0010, 1'b0, 1'b0);
    step(1'b1, 1'b1, 3'b110, 16'h0000, 1'b0, 1'b0);
    checks++; if (q8 !== 8'h11) $display("FAIL mid_inc_q got %h want 11", q8); else passed++;
    step(1'b0, 1'b1, 3'b110, 16'h0000, 1'b0, 1'b0);
    checks++; if (q8 !== 8'h5A) $display("FAIL mid_rst_q got %h want 5a", q8); else passed++;
    checks++; if (carry8 !== 1'b0) $display("FAIL mid_rst_carry got %b want 0", carry8); else passed++;
    checks++; if (changed8 !== 1'b0) $display("FAIL mid_rst_changed got %b want 0", changed8);
    else passed++;
    step(1'b1, 1'b1, 3'b110, 16'h0000, 1'b0, 1'b0);
    checks++; if (q8 !== 8'h5B) $display("FAIL post_rst_q got %h want 5b", q8); else passed++;
    checks++; if (changed8 !== 1'b1) $display("FAIL post_rst_changed got %b want 1", changed8);
    else passed++;
  endtask

  task automatic test_width4;
    step(1'b0, 1'b0, 3'b000, 16'h0000, 1'b0, 1'b0);
    checks++; if (q4 !== 4'h0) $display("FAIL w4_reset_q got %h want 0", q4); else passed++;
    step(1'b1, 1'b1, 3'b001, 16'h000F, 1'b0, 1'b0);
    step(1'b1, 1'b1, 3'b110, 16'h0000, 1'b0, 1'b0);
    checks++; if ({q4, carry4, zero4} !== {4'h0, 1'b1, 1'b1})
      $display("FAIL w4_inc_wrap got %h/%b/%b want 0/1/1", q4, carry4, zero4);
    else passed++;
    step(1'b1, 1'b1, 3'b001, 16'h0001, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 1'b1, 3'b010, 16'h0000, 1'b0, 1'b0);
      checks++;
      if (i < 4) begin
        if ({q4, carry4} !== {4'(1 << i), 1'b0})
          $display("FAIL w4_shl[%0d] got %h/%b want %h/0", i, q4, carry4, 4'(1 << i));
        else passed++;
      end else begin
        if ({q4, carry4} !== {4'h0, 1'b1})
          $display("FAIL w4_shl[%0d] got %h/%b want 0/1", i, q4, carry4);
        else passed++;
      end
    end
  endtask

  task automatic test_width16;
    step(1'b0, 1'b0, 3'b000, 16'h0000, 1'b0, 1'b0);
    checks++; if (q16 !== 16'h0000) $display("FAIL w16_reset_q got %h want 0000", q16); else passed++;
    step(1'b1, 1'b1, 3'b001, 16'hFFFF, 1'b0, 1'b0);
    step(1'b1, 1'b1, 3'b110, 16'h0000, 1'b0, 1'b0);
    checks++; if ({q16, carry16} !== {16'h0000, 1'b1})
      $display("FAIL w16_inc_wrap got %h/%b want 0000/1", q16, carry16);
    else passed++;
    step(1'b1, 1'b1, 3'b001, 16'h0001, 1'b0, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b1, 3'b010, 16'h0000, 1'b0, 1'b0);
      if (i == 15 || i == 16) begin
        checks++;
        if (i == 15) begin
          if ({q16, carry16, sol16} !== {16'h8000, 1'b0, 1'b1})
            $display("FAIL w16_shl15 got %h/%b/%b want 8000/0/1", q16, carry16, sol16);
          else passed++;
        end else begin
          if ({q16, carry16, zero16} !== {16'h0000, 1'b1, 1'b1})
            $display("FAIL w16_shl16 got %h/%b/%b want 0000/1/1", q16, carry16, zero16);
          else passed++;
        end
      end
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    enable   = 1'b0;
    mode     = 3'b000;
    d        = 16'h0000;
    ser_in_l = 1'b0;
    ser_in_r = 1'b0;
    test_reset();
    test_load_shift();
    test_rotate();
    test_counter_wrap();
    test_reset_mid_op();
    test_width4();
    test_width16();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
